// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types and SPI command tables for the IMU sequencer
package inert_pkg;

   typedef enum logic [1:0] {PWRUP, INIT_DN, IDLE, RD_DN} state_t;

   function automatic logic [15:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    init_cmd = 16'h0D02;
         2'd1:    init_cmd = 16'h1053;
         2'd2:    init_cmd = 16'h1150;
         default: init_cmd = 16'h1460;
      endcase
   endfunction

   // Read order: pitch low, pitch high, Z-accel low, Z-accel high
   function automatic logic [15:0] rd_cmd(input logic [1:0] i);
      case (i)
         2'd0:    rd_cmd = 16'hA200;
         2'd1:    rd_cmd = 16'hA300;
         2'd2:    rd_cmd = 16'hAC00;
         default: rd_cmd = 16'hAD00;
      endcase
   endfunction

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - two-flop synchronizer with rising-edge detect
module sync_rise (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = async_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/inert_spi_seq.sv
// rtl/inert_spi_seq.sv - IMU SPI sequencer: power-up config writes, then INT-driven read bursts
module inert_spi_seq
   import inert_pkg::*;
#(
   parameter int PWRUP_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld
);

   localparam int CW = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PWRUP_CYC - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    pl_q, pl_d, ph_q, ph_d, azl_q, azl_d;
   logic          pend_q, pend_d;
   logic          done_q;
   logic          wrt_q, wrt_d;
   logic [15:0]   cmd_q, cmd_d, ptch_q, ptch_d, az_q, az_d;
   logic          vld_q, vld_d;
   logic          int_rise, done_rise;

   sync_rise u_int_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (INT),
      .rise     (int_rise)
   );

   assign done_rise = done & ~done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pl_d    = pl_q;
      ph_d    = ph_q;
      azl_d   = azl_q;
      pend_d  = pend_q;
      wrt_d   = 1'b0;
      cmd_d   = cmd_q;
      ptch_d  = ptch_q;
      az_d    = az_q;
      vld_d   = 1'b0;
      case (state_q)
         PWRUP: begin
            if (cnt_q == CNT_LAST) begin
               wrt_d   = 1'b1;
               cmd_d   = init_cmd(2'd0);
               idx_d   = 2'd0;
               state_d = INIT_DN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         INIT_DN: begin
            if (done_rise) begin
               if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  wrt_d = 1'b1;
                  cmd_d = init_cmd(idx_q + 2'd1);
               end
            end
         end
         IDLE: begin
            if (pend_q || int_rise) begin
               pend_d  = 1'b0;
               wrt_d   = 1'b1;
               cmd_d   = rd_cmd(2'd0);
               idx_d   = 2'd0;
               state_d = RD_DN;
            end
         end
         RD_DN: begin
            if (int_rise) pend_d = 1'b1;
            if (done_rise) begin
               case (idx_q)
                  2'd0:    pl_d  = rd_data[7:0];
                  2'd1:    ph_d  = rd_data[7:0];
                  2'd2:    azl_d = rd_data[7:0];
                  default: ;
               endcase
               if (idx_q == 2'd3) begin
                  // High Z byte goes straight to the output; no staging needed
                  ptch_d  = {ph_q, pl_q};
                  az_d    = {rd_data[7:0], azl_q};
                  vld_d   = 1'b1;
                  idx_d   = 2'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  wrt_d = 1'b1;
                  cmd_d = rd_cmd(idx_q + 2'd1);
               end
            end
         end
         default: state_d = PWRUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PWRUP;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         pl_q    <= 8'h00;
         ph_q    <= 8'h00;
         azl_q   <= 8'h00;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         wrt_q   <= 1'b0;
         cmd_q   <= 16'h0000;
         ptch_q  <= 16'h0000;
         az_q    <= 16'h0000;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pl_q    <= pl_d;
         ph_q    <= ph_d;
         azl_q   <= azl_d;
         pend_q  <= pend_d;
         done_q  <= done;
         wrt_q   <= wrt_d;
         cmd_q   <= cmd_d;
         ptch_q  <= ptch_d;
         az_q    <= az_d;
         vld_q   <= vld_d;
      end
   end

   assign wrt     = wrt_q;
   assign cmd     = cmd_q;
   assign ptch_rt = ptch_q;
   assign AZ      = az_q;
   assign vld     = vld_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// tb/tb_inert_spi_seq.sv - scoreboard bench with an SPI master model for inert_spi_seq
module tb_inert_spi_seq;

   typedef struct {
      logic [7:0] pl, ph, azl, azh;
   } burst_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        INT;
   logic        done;
   logic [15:0] rd_data;
   logic        wrt;
   logic [15:0] cmd, ptch_rt, AZ;
   logic        vld;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int first_wrt_cyc = -1;
   int wrt_cnt = 0;
   int vld_cnt = 0;
   int reads_done = 0;
   bit hold_done = 1'b0;

   logic [15:0] exp_cmd_q[$];
   logic [31:0] exp_q[$];
   burst_t      bq[$];
   logic [15:0] last_p, last_a;

   inert_spi_seq #(.PWRUP_CYC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .INT     (INT),
      .done    (done),
      .rd_data (rd_data),
      .wrt     (wrt),
      .cmd     (cmd),
      .ptch_rt (ptch_rt),
      .AZ      (AZ),
      .vld     (vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SPI master model: done drops on wrt, rises 40 cycles later with the addressed byte
   initial begin : spi_master
      logic [7:0] c, b;
      bit aborted;
      done = 1'b1;
      rd_data = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (!rst && wrt && !hold_done) begin
            c = cmd[15:8];
            done = 1'b0;
            aborted = 1'b0;
            for (int i = 0; i < 40; i++) begin
               @(posedge clk); #1;
               if (rst) aborted = 1'b1;
            end
            if (!aborted && c[7]) begin
               b = 8'h00;
               if (bq.size() > 0) begin
                  case (c)
                     8'hA2: b = bq[0].pl;
                     8'hA3: b = bq[0].ph;
                     8'hAC: b = bq[0].azl;
                     8'hAD: begin b = bq[0].azh; void'(bq.pop_front()); end
                     default: b = 8'h00;
                  endcase
               end
               rd_data = {8'($urandom), b};
               reads_done++;
            end
            done = 1'b1;
         end
      end
   end

   // Monitor: checks every wrt and vld against the scoreboard queues
   always @(posedge clk) begin : monitor
      logic [31:0] e;
      cyc++;
      #1;
      if (rst) begin
         last_p = 16'h0;
         last_a = 16'h0;
      end else begin
         if (wrt) begin
            wrt_cnt++;
            if (first_wrt_cyc < 0) first_wrt_cyc = cyc - rel_cyc;
            if (exp_cmd_q.size() == 0) chk("wrt_unexpected", {16'h0, cmd}, 32'hFFFF_FFFF);
            else chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
         end
         if (vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) chk("vld_unexpected", {ptch_rt, AZ}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("ptch_rt", {16'h0, ptch_rt}, {16'h0, e[31:16]});
               chk("AZ", {16'h0, AZ}, {16'h0, e[15:0]});
            end
         end else begin
            chk("hold_outputs", {ptch_rt, AZ}, {last_p, last_a});
         end
         last_p = ptch_rt;
         last_a = AZ;
      end
   end

   task automatic push_init();
      exp_cmd_q.push_back(16'h0D02);
      exp_cmd_q.push_back(16'h1053);
      exp_cmd_q.push_back(16'h1150);
      exp_cmd_q.push_back(16'h1460);
   endtask

   task automatic expect_burst(input logic [7:0] pl, ph, azl, azh);
      burst_t b;
      b.pl = pl; b.ph = ph; b.azl = azl; b.azh = azh;
      bq.push_back(b);
      exp_q.push_back({ph, pl, azh, azl});
      exp_cmd_q.push_back(16'hA200);
      exp_cmd_q.push_back(16'hA300);
      exp_cmd_q.push_back(16'hAC00);
      exp_cmd_q.push_back(16'hAD00);
   endtask

   task automatic pulse_int();
      @(negedge clk); INT = 1'b1;
      repeat (3) @(negedge clk);
      INT = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_vld(input int target, input int budget);
      int n;
      n = 0;
      while (vld_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (vld_cnt < target) chk("vld_timeout", vld_cnt, target);
   endtask

   task automatic release_rst();
      @(negedge clk);
      first_wrt_cyc = -1;
      rel_cyc = cyc;
      wrt_cnt = 0;
      push_init();
      rst = 1'b0;
   endtask

   initial begin : stim
      int v0, w0, r0;
      logic [7:0] b0, b1, b2, b3;
      rst = 1'b1;
      INT = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wrt", {31'h0, wrt}, 32'h0);
      chk("rst_cmd", {16'h0, cmd}, 32'h0);
      chk("rst_ptch", {16'h0, ptch_rt}, 32'h0);
      chk("rst_az", {16'h0, AZ}, 32'h0);
      chk("rst_vld", {31'h0, vld}, 32'h0);

      // Power-up and config, with INT toggling that must be discarded
      release_rst();
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(2, 6)) @(negedge clk);
         INT = ~INT;
      end
      INT = 1'b0;
      repeat (250) @(negedge clk);
      chk("first_wrt_cycle", first_wrt_cyc, 8);
      chk("init_wrt_count", wrt_cnt, 4);
      chk("init_vld_count", vld_cnt, 0);
      chk("init_cmds_left", exp_cmd_q.size(), 0);

      // Single burst with known bytes
      expect_burst(8'h34, 8'h12, 8'hCD, 8'hAB);
      pulse_int();
      wait_vld(1, 1000);
      @(negedge clk);
      chk("burst_ptch", {16'h0, ptch_rt}, 32'h1234);
      chk("burst_az", {16'h0, AZ}, 32'hABCD);

      // Randomized bursts with random idle gaps
      for (int k = 0; k < 4; k++) begin
         b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
         v0 = vld_cnt;
         repeat ($urandom_range(5, 30)) @(negedge clk);
         expect_burst(b0, b1, b2, b3);
         pulse_int();
         wait_vld(v0 + 1, 1000);
      end

      // Two INT edges during a burst collapse into one extra burst
      v0 = vld_cnt;
      expect_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      expect_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      pulse_int();
      repeat (20) @(negedge clk);
      pulse_int();
      pulse_int();
      wait_vld(v0 + 2, 1500);
      repeat (300) @(negedge clk);
      chk("collapse_vld_count", vld_cnt - v0, 2);
      chk("collapse_cmds_left", exp_cmd_q.size(), 0);

      // Reset during a burst after its second read
      r0 = reads_done;
      v0 = vld_cnt;
      expect_burst(8'h5A, 8'hA5, 8'h3C, 8'hC3);
      pulse_int();
      while (reads_done < r0 + 2 && vld_cnt == v0) @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ptch", {16'h0, ptch_rt}, 32'h0);
      chk("midrst_az", {16'h0, AZ}, 32'h0);
      chk("midrst_wrt", {31'h0, wrt}, 32'h0);
      exp_cmd_q.delete();
      exp_q.delete();
      bq.delete();
      repeat (50) @(negedge clk);
      v0 = vld_cnt;
      release_rst();
      repeat (250) @(negedge clk);
      chk("rerun_first_wrt", first_wrt_cyc, 8);
      chk("rerun_wrt_count", wrt_cnt, 4);
      chk("rerun_ptch_zero", {16'h0, ptch_rt}, 32'h0);
      chk("rerun_az_zero", {16'h0, AZ}, 32'h0);
      chk("rerun_vld_count", vld_cnt, v0);
      expect_burst(8'h78, 8'h56, 8'h21, 8'h43);
      pulse_int();
      wait_vld(v0 + 1, 1000);

      // Master never clears done: sequencer must stall after one wrt
      repeat (10) @(negedge clk);
      hold_done = 1'b1;
      w0 = wrt_cnt;
      exp_cmd_q.push_back(16'hA200);
      pulse_int();
      repeat (300) @(negedge clk);
      chk("stall_wrt_count", wrt_cnt - w0, 1);
      chk("stall_cmds_left", exp_cmd_q.size(), 0);
      chk("final_vld_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
